// File: rtl/dual2ascii.sv
// dual2ascii: binary-to-ASCII display formatter for the bike-computer LCD.
// A start pulse captures speed/trip/time inputs. Two double-dabble engines
// run side by side: one for the 2-digit speed field and one for the 4-digit
// mode-selected field. Six registered ASCII character codes result.
// Fixed latency: start sampled at edge k, outputs and valid_out at edge k+16.

module dual2ascii (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [6:0]  speed,
    input  logic [6:0]  max_speed,
    input  logic [13:0] distance,
    input  logic [9:0]  avg_speed,
    input  logic [6:0]  hours,
    input  logic [5:0]  minutes,
    input  logic [5:0]  seconds,
    input  logic        AVS,
    input  logic        DAY,
    input  logic        MAX,
    input  logic        TIM,
    output logic [7:0]  upper10,
    output logic [7:0]  upper01,
    output logic [7:0]  lower1000,
    output logic [7:0]  lower0100,
    output logic [7:0]  lower0010,
    output logic [7:0]  lower0001,
    output logic        valid_out
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CONV = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] SEL_DAY = 2'd0;
    localparam logic [1:0] SEL_AVS = 2'd1;
    localparam logic [1:0] SEL_MAX = 2'd2;
    localparam logic [1:0] SEL_TIM = 2'd3;

    // 14 input bits shifted, counter runs 0..13.
    localparam logic [3:0] LAST_SHIFT = 4'd13;

    localparam logic [7:0] CH_BLANK = 8'h20;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    // Double-dabble correction: a BCD nibble of 5 or more gets +3 before the shift.
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // Decimal digit to ASCII code.
    function automatic logic [7:0] to_ch(input logic [3:0] d);
        return {4'h3, d};
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]  state;
    logic [3:0]  shift_cnt;

    // Inputs captured at the start edge.
    logic [6:0]  cap_speed;
    logic [6:0]  cap_max_speed;
    logic [13:0] cap_distance;
    logic [9:0]  cap_avg_speed;
    logic [6:0]  cap_hours;
    logic [5:0]  cap_minutes;
    logic [5:0]  cap_seconds;
    logic [1:0]  cap_sel;

    // Conversion engines: binary shift-out register plus BCD accumulator.
    logic [13:0] up_bin;
    logic [7:0]  up_bcd;
    logic [13:0] lo_bin;
    logic [15:0] lo_bcd;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [1:0]  sel_in;
    logic [6:0]  up_src;
    logic [6:0]  hh_sat;
    logic [6:0]  time_hi;
    logic [5:0]  time_lo;
    logic [13:0] time_hi14;
    logic [13:0] time_val;
    logic [13:0] lo_src;

    logic [7:0]  up_adj;
    logic [21:0] up_shift;
    logic [15:0] lo_adj;
    logic [29:0] lo_shift;

    logic [7:0]  upper10_n;
    logic [7:0]  upper01_n;
    logic [7:0]  lower1000_n;
    logic [7:0]  lower0100_n;
    logic [7:0]  lower0010_n;
    logic [7:0]  lower0001_n;

    // Resolve mode priority TIM > MAX > AVS > DAY; no mode behaves like DAY.
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no
        // path can leave it unassigned and infer a latch.
        sel_in = SEL_DAY;
        if (TIM)
            sel_in = SEL_TIM;
        else if (MAX)
            sel_in = SEL_MAX;
        else if (AVS)
            sel_in = SEL_AVS;
        else if (DAY)
            sel_in = SEL_DAY;
    end

    // Select and saturate the values loaded into the engines.
    always_comb begin
        up_src    = (cap_speed > 7'd99) ? 7'd99 : cap_speed;
        hh_sat    = (cap_hours > 7'd99) ? 7'd99 : cap_hours;
        // Time is folded into a single value hi*100 + lo, so the 4-digit
        // engine yields the two 2-digit fields directly (constant multiply).
        time_hi   = (cap_hours == 7'd0) ? {1'b0, cap_minutes} : hh_sat;
        time_lo   = (cap_hours == 7'd0) ? cap_seconds : cap_minutes;
        time_hi14 = {7'd0, time_hi};
        time_val  = (time_hi14 << 6) + (time_hi14 << 5) + (time_hi14 << 2)
                  + {8'd0, time_lo};
        case (cap_sel)
            SEL_TIM: lo_src = time_val;
            SEL_MAX: lo_src = {7'd0, cap_max_speed};
            SEL_AVS: lo_src = (cap_avg_speed > 10'd999) ? 14'd999
                                                        : {4'd0, cap_avg_speed};
            default: lo_src = (cap_distance > 14'd9999) ? 14'd9999
                                                        : cap_distance;
        endcase
    end

    // One double-dabble step for each engine: correct nibbles, then shift left.
    always_comb begin
        up_adj   = {add3(up_bcd[7:4]), add3(up_bcd[3:0])};
        up_shift = {up_adj, up_bin} << 1;
        lo_adj   = {add3(lo_bcd[15:12]), add3(lo_bcd[11:8]),
                    add3(lo_bcd[7:4]),   add3(lo_bcd[3:0])};
        lo_shift = {lo_adj, lo_bin} << 1;
    end

    // Encode the finished BCD digits as ASCII with per-mode blanking.
    always_comb begin
        upper10_n   = (up_bcd[7:4] == 4'd0) ? CH_BLANK : to_ch(up_bcd[7:4]);
        upper01_n   = to_ch(up_bcd[3:0]);
        lower1000_n = to_ch(lo_bcd[15:12]);
        lower0100_n = to_ch(lo_bcd[11:8]);
        lower0010_n = to_ch(lo_bcd[7:4]);
        lower0001_n = to_ch(lo_bcd[3:0]);
        case (cap_sel)
            SEL_TIM: begin
                // MMSS / HHMM: every position is a digit.
            end
            SEL_MAX: begin
                lower1000_n = CH_BLANK;
                if (lo_bcd[11:8] == 4'd0)
                    lower0100_n = CH_BLANK;
                if (lo_bcd[11:4] == 8'd0)
                    lower0010_n = CH_BLANK;
            end
            SEL_AVS: begin
                // XX.X: tenths and units always shown.
                lower1000_n = CH_BLANK;
                if (lo_bcd[11:8] == 4'd0)
                    lower0100_n = CH_BLANK;
            end
            default: begin
                // XXX.X: only the two leading positions may blank.
                if (lo_bcd[15:12] == 4'd0)
                    lower1000_n = CH_BLANK;
                if (lo_bcd[15:8] == 8'd0)
                    lower0100_n = CH_BLANK;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    // Control FSM, shift counter and registered outputs; reset aborts everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            shift_cnt <= 4'd0;
            valid_out <= 1'b0;
            upper10   <= CH_BLANK;
            upper01   <= CH_BLANK;
            lower1000 <= CH_BLANK;
            lower0100 <= CH_BLANK;
            lower0010 <= CH_BLANK;
            lower0001 <= CH_BLANK;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            valid_out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start)
                        state <= ST_LOAD;
                end
                ST_LOAD: begin
                    shift_cnt <= 4'd0;
                    state     <= ST_CONV;
                end
                ST_CONV: begin
                    shift_cnt <= shift_cnt + 4'd1;
                    if (shift_cnt == LAST_SHIFT)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    upper10   <= upper10_n;
                    upper01   <= upper01_n;
                    lower1000 <= lower1000_n;
                    lower0100 <= lower0100_n;
                    lower0010 <= lower0010_n;
                    lower0001 <= lower0001_n;
                    valid_out <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Input capture and the two conversion engines.
    // NOTE: datapath registers carry no reset; they are always written
    // (capture, then LOAD) before their contents reach the outputs.
    always_ff @(posedge clock) begin
        if (!reset && state == ST_IDLE && start) begin
            cap_speed     <= speed;
            cap_max_speed <= max_speed;
            cap_distance  <= distance;
            cap_avg_speed <= avg_speed;
            cap_hours     <= hours;
            cap_minutes   <= minutes;
            cap_seconds   <= seconds;
            cap_sel       <= sel_in;
        end

        if (state == ST_LOAD) begin
            up_bin <= {7'd0, up_src};
            up_bcd <= 8'd0;
            lo_bin <= lo_src;
            lo_bcd <= 16'd0;
        end else if (state == ST_CONV) begin
            up_bcd <= up_shift[21:14];
            up_bin <= up_shift[13:0];
            lo_bcd <= lo_shift[29:14];
            lo_bin <= lo_shift[13:0];
        end
    end

endmodule

// File: tb/tb_dual2ascii.sv
// Self-checking bench for dual2ascii: a directed vector table with
// hand-derived ASCII strings, multi-cycle corner sequences (reset abort,
// busy restart, start during DONE, start on first IDLE cycle), and random
// vectors checked against an arithmetic reference model.

module tb_dual2ascii;

    typedef struct {
        logic [6:0]  speed;
        logic [6:0]  max_speed;
        logic [13:0] distance;
        logic [9:0]  avg_speed;
        logic [6:0]  hours;
        logic [5:0]  minutes;
        logic [5:0]  seconds;
        logic [3:0]  mode;      // {TIM, MAX, AVS, DAY}
        logic [15:0] up;
        logic [31:0] lo;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [6:0]  speed;
    logic [6:0]  max_speed;
    logic [13:0] distance;
    logic [9:0]  avg_speed;
    logic [6:0]  hours;
    logic [5:0]  minutes;
    logic [5:0]  seconds;
    logic        AVS, DAY, MAX, TIM;
    logic [7:0]  upper10, upper01, lower1000, lower0100, lower0010, lower0001;
    logic        valid_out;

    int n_vectors = 0;
    int n_miscompares = 0;

    dual2ascii dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .speed     (speed),
        .max_speed (max_speed),
        .distance  (distance),
        .avg_speed (avg_speed),
        .hours     (hours),
        .minutes   (minutes),
        .seconds   (seconds),
        .AVS       (AVS),
        .DAY       (DAY),
        .MAX       (MAX),
        .TIM       (TIM),
        .upper10   (upper10),
        .upper01   (upper01),
        .lower1000 (lower1000),
        .lower0100 (lower0100),
        .lower0010 (lower0010),
        .lower0001 (lower0001),
        .valid_out (valid_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        speed     = v.speed;
        max_speed = v.max_speed;
        distance  = v.distance;
        avg_speed = v.avg_speed;
        hours     = v.hours;
        minutes   = v.minutes;
        seconds   = v.seconds;
        {TIM, MAX, AVS, DAY} = v.mode;
    endtask

    // Pulse start (sampled at edge k = offset 0), then watch 40 edges.
    // If restart_at > 0, apply alt and raise start so it is sampled at k+restart_at.
    task automatic run(input int restart_at, input vec_t alt,
                       output int first, output int last, output int pulses,
                       output logic [15:0] up1, output logic [31:0] lo1,
                       output logic [15:0] up2, output logic [31:0] lo2);
        first = -1; last = -1; pulses = 0;
        up1 = '0; lo1 = '0; up2 = '0; lo2 = '0;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            if (n == restart_at) begin
                apply(alt);
                start = 1'b1;
            end
            @(posedge clock); #1;
            start = 1'b0;
            if (valid_out === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first = n;
                    up1 = {upper10, upper01};
                    lo1 = {lower1000, lower0100, lower0010, lower0001};
                end
                last = n;
                up2 = {upper10, upper01};
                lo2 = {lower1000, lower0100, lower0010, lower0001};
            end
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] dc(input int d);
        return 8'(48 + d);
    endfunction

    function automatic logic [47:0] model(input vec_t v);
        int sp, a, b, x;
        logic [7:0] u1, u0, c3, c2, c1, c0;
        sp = (int'(v.speed) > 99) ? 99 : int'(v.speed);
        u1 = (sp >= 10) ? dc(sp / 10) : 8'h20;
        u0 = dc(sp % 10);
        if (v.mode[3]) begin
            if (v.hours == 0) begin
                a = int'(v.minutes); b = int'(v.seconds);
            end else begin
                a = (int'(v.hours) > 99) ? 99 : int'(v.hours);
                b = int'(v.minutes);
            end
            c3 = dc(a / 10); c2 = dc(a % 10); c1 = dc(b / 10); c0 = dc(b % 10);
        end else if (v.mode[2]) begin
            x = int'(v.max_speed);
            c3 = 8'h20;
            c2 = (x >= 100) ? dc(x / 100) : 8'h20;
            c1 = (x >= 10) ? dc((x / 10) % 10) : 8'h20;
            c0 = dc(x % 10);
        end else if (v.mode[1]) begin
            x = (int'(v.avg_speed) > 999) ? 999 : int'(v.avg_speed);
            c3 = 8'h20;
            c2 = (x >= 100) ? dc(x / 100) : 8'h20;
            c1 = dc((x / 10) % 10);
            c0 = dc(x % 10);
        end else begin
            x = (int'(v.distance) > 9999) ? 9999 : int'(v.distance);
            c3 = (x >= 1000) ? dc(x / 1000) : 8'h20;
            c2 = (x >= 100) ? dc((x / 100) % 10) : 8'h20;
            c1 = dc((x / 10) % 10);
            c0 = dc(x % 10);
        end
        return {u1, u0, c3, c2, c1, c0};
    endfunction

    vec_t tbl[14];
    vec_t v, alt;
    int first, last, pulses, cnt;
    logic [15:0] up1, up2;
    logic [31:0] lo1, lo2;
    logic [47:0] exp_v;

    initial begin
        //        speed  max    dist       avg       hrs     min    sec    {T,M,A,D}
        tbl[0]  = '{7'd69, 7'd0,  14'd920,   10'd0,    7'd0,   6'd0,  6'd0,  4'b0000, "69", " 920"};
        tbl[1]  = '{7'd69, 7'd0,  14'd920,   10'd33,   7'd0,   6'd0,  6'd0,  4'b0010, "69", "  33"};
        tbl[2]  = '{7'd69, 7'd50, 14'd920,   10'd33,   7'd0,   6'd0,  6'd0,  4'b0001, "69", " 920"};
        tbl[3]  = '{7'd69, 7'd50, 14'd920,   10'd33,   7'd0,   6'd0,  6'd0,  4'b0100, "69", "  50"};
        tbl[4]  = '{7'd69, 7'd50, 14'd920,   10'd33,   7'd0,   6'd28, 6'd22, 4'b1000, "69", "2822"};
        tbl[5]  = '{7'd69, 7'd50, 14'd920,   10'd33,   7'd5,   6'd7,  6'd40, 4'b1000, "69", "0507"};
        tbl[6]  = '{7'd69, 7'd50, 14'd920,   10'd33,   7'd120, 6'd7,  6'd40, 4'b1000, "69", "9907"};
        tbl[7]  = '{7'd69, 7'd50, 14'd16383, 10'd33,   7'd0,   6'd0,  6'd0,  4'b0000, "69", "9999"};
        tbl[8]  = '{7'd69, 7'd50, 14'd920,   10'd1023, 7'd0,   6'd0,  6'd0,  4'b0010, "69", " 999"};
        tbl[9]  = '{7'd127,7'd50, 14'd7,     10'd0,    7'd0,   6'd0,  6'd0,  4'b0000, "99", "   0"};
        tbl[10] = '{7'd5,  7'd0,  14'd920,   10'd0,    7'd0,   6'd0,  6'd0,  4'b0100, " 5", "   0"};
        tbl[11] = '{7'd0,  7'd99, 14'd1234,  10'd100,  7'd0,   6'd1,  6'd2,  4'b1111, " 0", "0102"};
        tbl[12] = '{7'd10, 7'd127,14'd1234,  10'd100,  7'd3,   6'd1,  6'd2,  4'b0111, "10", " 127"};
        tbl[13] = '{7'd99, 7'd9,  14'd1234,  10'd100,  7'd3,   6'd1,  6'd2,  4'b0011, "99", " 100"};
        // tbl[9] distance 7 shows "   0"? No: default mode, 7 -> 0.7 -> "  07".
        tbl[9].lo = "  07";

        reset = 1'b1;
        start = 1'b0;
        apply(tbl[0]);

        // Reset held 30 cycles.
        repeat (30) @(posedge clock);
        #1;
        check("reset_valid", 64'(valid_out), 64'd0);
        check("reset_upper", 64'({upper10, upper01}), 64'(16'h2020));
        check("reset_lower", 64'({lower1000, lower0100, lower0010, lower0001}), 64'(32'h20202020));
        reset = 1'b0;
        @(posedge clock); #1;

        // Reset during a conversion, with start pulsed under reset: no valid_out.
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        cnt = 0;
        for (int n = 0; n < 25; n++) begin
            @(posedge clock); #1;
            if (valid_out === 1'b1) cnt++;
        end
        check("abort_no_valid", 64'(cnt), 64'd0);
        check("abort_upper", 64'({upper10, upper01}), 64'(16'h2020));

        // Directed table.
        for (int i = 0; i < 14; i++) begin
            apply(tbl[i]);
            run(-1, tbl[i], first, last, pulses, up1, lo1, up2, lo2);
            check($sformatf("tbl%0d_latency", i), 64'(first), 64'd16);
            check($sformatf("tbl%0d_pulses", i), 64'(pulses), 64'd1);
            check($sformatf("tbl%0d_upper", i), 64'(up1), 64'(tbl[i].up));
            check($sformatf("tbl%0d_lower", i), 64'(lo1), 64'(tbl[i].lo));
        end

        // Busy: second start at k+3 with changed data and mode is ignored.
        alt = '{7'd10, 7'd77, 14'd1234, 10'd555, 7'd2, 6'd33, 6'd44, 4'b1000, "10", "0233"};
        apply(tbl[0]);
        run(3, alt, first, last, pulses, up1, lo1, up2, lo2);
        check("busy_latency", 64'(first), 64'd16);
        check("busy_pulses", 64'(pulses), 64'd1);
        check("busy_upper", 64'(up1), 64'(16'h3639));
        check("busy_lower", 64'(lo1), 64'(32'h20393230));

        // Start sampled in DONE (k+16) is ignored.
        apply(tbl[3]);
        run(16, tbl[3], first, last, pulses, up1, lo1, up2, lo2);
        check("done_start_pulses", 64'(pulses), 64'd1);
        check("done_start_lower", 64'(lo1), 64'("  50"));

        // Start on the first IDLE cycle (k+17) converts, result at k+33.
        alt = '{7'd0, 7'd7, 14'd0, 10'd0, 7'd0, 6'd0, 6'd0, 4'b0100, " 0", "   7"};
        apply(tbl[4]);
        run(17, alt, first, last, pulses, up1, lo1, up2, lo2);
        check("idle_start_pulses", 64'(pulses), 64'd2);
        check("idle_start_second", 64'(last), 64'd33);
        check("idle_start_lower1", 64'(lo1), 64'("2822"));
        check("idle_start_upper2", 64'(up2), 64'(alt.up));
        check("idle_start_lower2", 64'(lo2), 64'(alt.lo));

        // Random vectors against the reference model.
        for (int i = 0; i < 40; i++) begin
            v.speed     = 7'($urandom_range(0, 127));
            v.max_speed = 7'($urandom_range(0, 127));
            v.distance  = 14'($urandom_range(0, 16383));
            v.avg_speed = 10'($urandom_range(0, 1023));
            v.hours     = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(0, 127));
            v.minutes   = 6'($urandom_range(0, 59));
            v.seconds   = 6'($urandom_range(0, 59));
            v.mode      = 4'($urandom_range(0, 15));
            v.up        = '0;
            v.lo        = '0;
            exp_v = model(v);
            apply(v);
            run(-1, v, first, last, pulses, up1, lo1, up2, lo2);
            check($sformatf("rnd%0d_latency", i), 64'(first), 64'd16);
            check($sformatf("rnd%0d_chars", i), 64'({up1, lo1}), 64'(exp_v));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/dual2ascii.md
# dual2ascii

Display formatter for the bike-computer front end: on a `start` pulse it captures the current speed, trip and time values, converts them from binary to decimal, and drives six ASCII character codes for the LCD. The upper 2-digit field always shows current speed. The lower 4-digit field shows the quantity selected by the mode buttons. It sits between the measurement/timekeeping datapath and the LCD character driver.

## Interface
- No parameters.
- `clock`  in  1  system clock, rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request: capture inputs and convert.
- `speed`  in  7  current speed, km/h, 0..127.
- `max_speed`  in  7  maximum speed, km/h.
- `distance`  in  14  trip distance, units of 0.1 km.
- `avg_speed`  in  10  average speed, units of 0.1 km/h.
- `hours`  in  7  elapsed hours.
- `minutes`  in  6  elapsed minutes, 0..59.
- `seconds`  in  6  elapsed seconds, 0..59.
- `AVS`, `DAY`, `MAX`, `TIM`  in  1 each  mode selects.
- `upper10`, `upper01`  out  8 each  ASCII tens/units of the upper field.
- `lower1000`, `lower0100`, `lower0010`, `lower0001`  out  8 each  ASCII lower field, most significant first.
- `valid_out`  out  1  one-cycle pulse when the outputs have just been updated.

## Operation
- Idle until `start`=1 at a rising edge. That edge captures all data and mode inputs into internal registers. Later input changes do not affect the running conversion.
- Mode priority: TIM > MAX > AVS > DAY. With no mode set, the lower field shows distance, the same as DAY.
- Upper field: `speed`, saturated to 99, two digits. Leading zero is blanked (0x20). Value 0 shows " 0".
- DAY/default: `distance` saturated to 9999, shown as XXX.X. The decimal point is implied between lower0010 and lower0001. Blank leading zeros in lower1000 and lower0100 only.
- AVS: `avg_speed` saturated to 999, shown as XX.X. lower1000 is always blank. Blank lower0100 if its digit is zero.
- MAX: `max_speed` as an integer. lower1000 is always blank. Blank leading zeros in lower0100 and lower0010. lower0001 is always a digit.
- TIM, hours == 0: MMSS.
  - lower1000/lower0100 = minutes tens/units.
  - lower0010/lower0001 = seconds tens/units.
  - No blanking.
- TIM, hours > 0: HHMM, with hours saturated to 99. No blanking.
- Digit d encodes as 0x30+d. Blank encodes as 0x20.
- Conversion is sequential: shift-add-3 (double dabble), one input bit per cycle. The upper and lower fields run in parallel engines. Combinational divide is not allowed.
- Outputs are registered. They hold their value between conversions and change only at the `valid_out` edge.

## Timing
- Reset has priority over everything.
  - All six character outputs = 0x20. `valid_out` = 0.
  - FSM goes to IDLE and any conversion in progress is aborted.
- FSM states:
  - IDLE: `start` → LOAD.
  - LOAD: one cycle. Select and saturate the source values.
  - CONV: exactly 14 shift cycles.
  - DONE: one cycle. Encode to ASCII, write outputs, `valid_out`=1, then go to IDLE.
- Fixed latency: `start` sampled at edge k means outputs update and `valid_out` rises at edge k+16. `valid_out` is high for exactly one cycle.
- TIM mode passes the two 2-digit fields through the same engine. Its latency is also 16 cycles.
- `start` asserted while not in IDLE is ignored; no queuing.
- `start` in the same cycle as DONE is ignored. A new conversion may start on the first IDLE cycle.
- Mode inputs changing while busy have no effect until the next `start`.

## Test plan
- Reset held 30 cycles → all outputs 0x20, `valid_out`=0. Pulse `start` mid-conversion while `reset`=1 → no `valid_out`.
- speed=69, distance=920, no mode, `start` → at k+16, upper = "69" (0x36,0x39) and lower = " 920" (0x20,0x39,0x32,0x30). `valid_out` high for one cycle only.
- AVS=1, avg_speed=33 → lower "  33" (0x20,0x20,0x33,0x33). DAY=1 → " 920". MAX=1, max_speed=50 → "  50".
- TIM=1, hours=0, minutes=28, seconds=22 → "2822". hours=5, minutes=7 → "0507". hours=120 → "99MM".
- Saturation: distance=16383 → "9999". avg_speed=1023 → " 999". speed=127 → "99". speed=5 → " 5". max_speed=0 → "   0".
- Second `start` at k+3 plus mode change while busy → ignored. Result reflects the k-captured inputs. Exactly one `valid_out` pulse.
